// File: rtl/axis_pkg.sv
// Shared AXI-Stream sample types and the frame packer state encoding.
package axis_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } sample_t_int;

    typedef sample_t_int sample_t;

    typedef enum logic [1:0] {
        FILL = 2'b00,
        PAD  = 2'b01,
        DROP = 2'b10
    } pack_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream holding register: BUS_NUM lanes plus last, with valid/ready.
module axis_out_reg
    import axis_pkg::*;
#(
    parameter int BUS_NUM = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  sample_t_int i_data [BUS_NUM],
    input  logic        i_last,
    input  logic        i_ready,
    output logic        o_valid,
    output logic        o_last,
    output sample_t_int o_data [BUS_NUM],
    output logic        o_free
);

    logic        r_valid;
    logic        r_last;
    sample_t_int r_data [BUS_NUM];

    // Caller only asserts i_load when o_free, so a load always wins over a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '{default: '0};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_last  <= i_last;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_data  = r_data;
    assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/axis_frame_packer.sv
// Packs BUS_NUM serial samples per output beat and repairs frames to exactly FFT_SIZE samples.
module axis_frame_packer
    import axis_pkg::*;
#(
    parameter int FFT_SIZE = 8192,
    parameter int BUS_NUM  = 2,
    parameter int BEAT_AW  = $clog2(FFT_SIZE / BUS_NUM),
    parameter int LANE_AW  = $clog2(BUS_NUM)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic        in_tlast,
    input  sample_t_int in_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output sample_t_int out_tdata [BUS_NUM],
    output logic        err_short,
    output logic        err_long,
    output logic [15:0] frame_cnt
);

    localparam int BEATS = FFT_SIZE / BUS_NUM;

    pack_state_t         r_state, w_state_nx;
    logic [LANE_AW-1:0]  r_lane_idx, w_lane_nx;
    logic [BEAT_AW-1:0]  r_beat_cntr, w_beat_nx;
    sample_t_int         r_pack [BUS_NUM-1];
    logic                r_rdy_en;
    logic                r_err_short, r_err_long;
    logic [15:0]         r_frame_cnt;

    sample_t_int         w_beat [BUS_NUM];
    logic                w_load, w_pack_wr, w_pack_clr;
    logic                w_err_s, w_err_l, w_tready;
    logic                w_free, w_last_lane, w_last_beat;

    assign w_last_lane = (r_lane_idx == LANE_AW'(BUS_NUM - 1));
    assign w_last_beat = (r_beat_cntr == BEAT_AW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_state_nx;
    end

    // Pack lanes above r_lane_idx are always zero (cleared on every load), so the
    // pack itself doubles as the zero-filled partial beat when a short frame ends
    // while the output is blocked; PAD then emits it as its first beat.
    always_comb begin
        w_state_nx = r_state;
        w_lane_nx  = r_lane_idx;
        w_beat_nx  = r_beat_cntr;
        w_load     = 1'b0;
        w_pack_wr  = 1'b0;
        w_pack_clr = 1'b0;
        w_err_s    = 1'b0;
        w_err_l    = 1'b0;
        w_tready   = 1'b0;
        w_beat     = '{default: '0};
        for (int unsigned i = 0; i < BUS_NUM - 1; i++) w_beat[i] = r_pack[i];

        case (r_state)
            FILL: begin
                w_tready = r_rdy_en && !(w_last_lane && out_tvalid && !out_tready);
                for (int unsigned i = 0; i < BUS_NUM; i++)
                    if (LANE_AW'(i) == r_lane_idx) w_beat[i] = in_tdata;
                if (in_tvalid && w_tready) begin
                    w_err_s = in_tlast && !(w_last_lane && w_last_beat);
                    if (w_last_lane || (in_tlast && w_free)) begin
                        w_load     = 1'b1;
                        w_pack_clr = 1'b1;
                        w_lane_nx  = '0;
                        w_beat_nx  = r_beat_cntr + 1'b1;
                        if (w_last_beat && !in_tlast) begin
                            w_err_l    = 1'b1;
                            w_state_nx = DROP;
                        end else if (!w_last_beat && in_tlast) begin
                            w_state_nx = PAD;
                        end
                    end else if (in_tlast) begin
                        w_pack_wr  = 1'b1;
                        w_lane_nx  = '0;
                        w_state_nx = PAD;
                    end else begin
                        w_pack_wr = 1'b1;
                        w_lane_nx = r_lane_idx + 1'b1;
                    end
                end
            end
            PAD: begin
                if (w_free) begin
                    w_load     = 1'b1;
                    w_pack_clr = 1'b1;
                    w_beat_nx  = r_beat_cntr + 1'b1;
                    if (w_last_beat) w_state_nx = FILL;
                end
            end
            DROP: begin
                w_tready = r_rdy_en;
                if (in_tvalid && w_tready && in_tlast) w_state_nx = FILL;
            end
            default: w_state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_idx  <= '0;
            r_beat_cntr <= '0;
            r_pack      <= '{default: '0};
            r_rdy_en    <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_lane_idx  <= w_lane_nx;
            r_beat_cntr <= w_beat_nx;
            r_rdy_en    <= 1'b1;
            r_err_short <= w_err_s;
            r_err_long  <= w_err_l;
            for (int unsigned i = 0; i < BUS_NUM - 1; i++) begin
                if (w_pack_clr)
                    r_pack[i] <= '0;
                else if (w_pack_wr && LANE_AW'(i) == r_lane_idx)
                    r_pack[i] <= in_tdata;
            end
            if (out_tvalid && out_tready && out_tlast)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    axis_out_reg #(
        .BUS_NUM (BUS_NUM)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_beat),
        .i_last  (w_last_beat),
        .i_ready (out_tready),
        .o_valid (out_tvalid),
        .o_last  (out_tlast),
        .o_data  (out_tdata),
        .o_free  (w_free)
    );

    assign in_tready = w_tready;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Directed bench for axis_frame_packer: FFT_SIZE=16 with BUS_NUM=2 and BUS_NUM=4 instances.
module tb_axis_frame_packer;
    import axis_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_tvalid, in_tlast, out_tready;
    sample_t_int in_tdata;
    logic        in_tready, out_tvalid, out_tlast, err_short, err_long;
    sample_t_int out_tdata [2];
    logic [15:0] frame_cnt;

    logic        in_tvalid4, in_tlast4, out_tready4;
    sample_t_int in_tdata4;
    logic        in_tready4, out_tvalid4, out_tlast4, err_short4, err_long4;
    sample_t_int out_tdata4 [4];
    logic [15:0] frame_cnt4;

    int total = 0, bad = 0, timeouts = 0;
    int n_es = 0, n_el = 0, acc_cnt = 0, stall_bad = 0, rdy_bad = 0;
    logic bp = 1'b0, rdy_chk = 1'b0, prev_stall = 1'b0;
    logic [64:0]  prev_beat;
    logic [64:0]  q2[$], e2[$];
    logic [128:0] q4[$], e4[$];

    always #5 clk = ~clk;

    axis_frame_packer #(.FFT_SIZE(16), .BUS_NUM(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .in_tlast(in_tlast), .in_tdata(in_tdata), .out_tvalid(out_tvalid),
        .out_tready(out_tready), .out_tlast(out_tlast), .out_tdata(out_tdata),
        .err_short(err_short), .err_long(err_long), .frame_cnt(frame_cnt));

    axis_frame_packer #(.FFT_SIZE(16), .BUS_NUM(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_tvalid(in_tvalid4), .in_tready(in_tready4),
        .in_tlast(in_tlast4), .in_tdata(in_tdata4), .out_tvalid(out_tvalid4),
        .out_tready(out_tready4), .out_tlast(out_tlast4), .out_tdata(out_tdata4),
        .err_short(err_short4), .err_long(err_long4), .frame_cnt(frame_cnt4));

    function automatic sample_t_int mk(input int v);
        sample_t_int s;
        s.re = 16'(v);
        s.im = 16'(-v);
        return s;
    endfunction

    function automatic logic [64:0] eb2(input int a, input int b, input logic last);
        return {mk(b), mk(a), last};
    endfunction

    function automatic logic [128:0] eb4(input int a, input logic last);
        return {mk(a + 3), mk(a + 2), mk(a + 1), mk(a), last};
    endfunction

    // Monitor: capture output handshakes, count error pulses, watch stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ({out_tdata[1], out_tdata[0], out_tlast} !== prev_beat || !out_tvalid))
                stall_bad++;
            prev_stall = out_tvalid && !out_tready;
            prev_beat  = {out_tdata[1], out_tdata[0], out_tlast};
            if (rdy_chk && in_tready !== !(acc_cnt[0] && out_tvalid && !out_tready))
                rdy_bad++;
            if (in_tvalid && in_tready) acc_cnt++;
            if (out_tvalid && out_tready) q2.push_back({out_tdata[1], out_tdata[0], out_tlast});
            if (out_tvalid4 && out_tready4)
                q4.push_back({out_tdata4[3], out_tdata4[2], out_tdata4[1], out_tdata4[0], out_tlast4});
            if (err_short) n_es++;
            if (err_long)  n_el++;
        end
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp) out_tready = !out_tready;
    endtask

    task automatic send(input int v, input logic last);
        logic acc;
        int   n = 0;
        in_tvalid = 1'b1; in_tdata = mk(v); in_tlast = last;
        do begin
            @(negedge clk); acc = in_tready; tick(); n++;
        end while (!acc && n < 200);
        if (!acc) timeouts++;
        in_tlast = 1'b0;
    endtask

    task automatic send4(input int v, input logic last);
        logic acc;
        int   n = 0;
        in_tvalid4 = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        in_tvalid4 = 1'b1; in_tdata4 = mk(v); in_tlast4 = last;
        do begin
            @(negedge clk); acc = in_tready4; tick(); n++;
        end while (!acc && n < 200);
        if (!acc) timeouts++;
        in_tvalid4 = 1'b0; in_tlast4 = 1'b0;
    endtask

    task automatic drain2();
        int k = 0;
        in_tvalid = 1'b0;
        while (q2.size() < e2.size() && k < 80) begin tick(); k++; end
        tick(); tick();
    endtask

    task automatic cmp2(input string tag);
        logic [64:0] got;
        chk({tag, "_nbeats"}, q2.size(), e2.size());
        foreach (e2[i]) begin
            got = (i < q2.size()) ? q2[i] : 'x;
            chk($sformatf("%s_beat%0d", tag, i), got, e2[i]);
        end
        q2.delete(); e2.delete();
    endtask

    task automatic exp_nom(input int base);
        for (int k = 0; k < 8; k++) e2.push_back(eb2(base + 2*k + 1, base + 2*k + 2, k == 7));
    endtask

    initial begin
        rst_n = 1'b0; out_tready = 1'b1; out_tready4 = 1'b1;
        in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0;
        in_tvalid4 = 1'b0; in_tlast4 = 1'b0; in_tdata4 = '0;
        tick(); tick();
        chk("rst_outs", {in_tready, out_tvalid, out_tlast, err_short, err_long}, 5'b0);
        chk("rst_data", {out_tdata[1], out_tdata[0], frame_cnt}, 80'b0);
        rst_n = 1'b1;
        #0 chk("rdy_at_deassert", in_tready, 1'b0);
        tick();
        chk("rdy_after_1cyc", in_tready, 1'b1);

        // Nominal frame with latency checks on the first beat
        send(1, 1'b0);
        chk("no_beat_after_s1", out_tvalid, 1'b0);
        send(2, 1'b0);
        chk("beat0_latency", {out_tvalid, out_tdata[1], out_tdata[0], out_tlast}, {1'b1, eb2(1, 2, 1'b0)});
        for (int s = 3; s <= 16; s++) send(s, s == 16);
        exp_nom(0);
        drain2();
        cmp2("nom");
        chk("nom_fcnt", frame_cnt, 16'd1);
        chk("nom_errs", {n_es[7:0], n_el[7:0]}, 16'd0);

        // Back-pressure: out_tready toggles every cycle
        acc_cnt = 0; rdy_chk = 1'b1; bp = 1'b1;
        for (int s = 1; s <= 16; s++) send(s, s == 16);
        exp_nom(0);
        drain2();
        rdy_chk = 1'b0; bp = 1'b0; out_tready = 1'b1;
        cmp2("bp");
        chk("bp_stall_stable", stall_bad, 0);
        chk("bp_tready_rule", rdy_bad, 0);
        chk("bp_fcnt", frame_cnt, 16'd2);

        // Short frame: tlast on sample 5
        for (int s = 1; s <= 4; s++) send(s, 1'b0);
        send(5, 1'b1);
        chk("short_pad_tready", in_tready, 1'b0);
        e2.push_back(eb2(1, 2, 1'b0)); e2.push_back(eb2(3, 4, 1'b0)); e2.push_back(eb2(5, 0, 1'b0));
        for (int k = 3; k < 8; k++) e2.push_back(eb2(0, 0, k == 7));
        drain2();
        cmp2("short");
        chk("short_err_pulses", {n_es[7:0], n_el[7:0]}, {8'd1, 8'd0});
        chk("short_fcnt", frame_cnt, 16'd3);

        // Long frame: 20 samples, then a nominal frame
        for (int s = 1; s <= 20; s++) send(s, s == 20);
        for (int s = 101; s <= 116; s++) send(s, s == 116);
        exp_nom(0); exp_nom(100);
        drain2();
        cmp2("long");
        chk("long_err_pulses", {n_es[7:0], n_el[7:0]}, {8'd1, 8'd1});
        chk("long_fcnt", frame_cnt, 16'd5);

        // Reset mid-frame after 7 samples
        for (int s = 1; s <= 7; s++) send(s, 1'b0);
        in_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {in_tready, out_tvalid, out_tlast, err_short, err_long}, 5'b0);
        chk("midrst_data", {out_tdata[1], out_tdata[0], frame_cnt}, 80'b0);
        tick();
        rst_n = 1'b1;
        tick();
        q2.delete();
        for (int s = 201; s <= 216; s++) send(s, s == 216);
        exp_nom(200);
        drain2();
        cmp2("postrst");
        chk("postrst_fcnt", frame_cnt, 16'd1);

        // BUS_NUM=4: three back-to-back frames with random valid gaps
        for (int f = 0; f < 3; f++)
            for (int s = 1; s <= 16; s++) send4(16*f + s, s == 16);
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 4; k++) e4.push_back(eb4(16*f + 4*k + 1, k == 3));
        for (int k = 0; k < 40 && q4.size() < e4.size(); k++) tick();
        tick(); tick();
        chk("b4_nbeats", q4.size(), e4.size());
        foreach (e4[i]) chk($sformatf("b4_beat%0d", i), (i < q4.size()) ? q4[i] : 'x, e4[i]);
        chk("b4_fcnt", frame_cnt4, 16'd3);
        chk("b4_errs", {err_short4, err_long4}, 2'b00);
        chk("timeouts", timeouts, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
